// File: rtl/mcr_rom_arbiter_if.sv
// rtl/mcr_rom_arbiter_if.sv - download, CPU fetch and ROM bus bundle for mcr_rom_arbiter
interface mcr_rom_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          dl_active;
   logic          dl_wr;
   logic [AW-1:0] dl_addr;
   logic [DW-1:0] dl_data;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_data;
   logic          cpu_ack;
   logic          snd_req;
   logic [13:0]   snd_addr;
   logic [DW-1:0] snd_data;
   logic          snd_ack;
   logic [AW-1:0] rom_addr;
   logic          rom_we;
   logic [DW-1:0] rom_d;
   logic [DW-1:0] rom_q;
   logic          busy;

   modport slave (
      input  dl_active, dl_wr, dl_addr, dl_data,
      input  cpu_req, cpu_addr, snd_req, snd_addr, rom_q,
      output cpu_data, cpu_ack, snd_data, snd_ack,
      output rom_addr, rom_we, rom_d, busy
   );

   modport master (
      output dl_active, dl_wr, dl_addr, dl_data,
      output cpu_req, cpu_addr, snd_req, snd_addr, rom_q,
      input  cpu_data, cpu_ack, snd_data, snd_ack,
      input  rom_addr, rom_we, rom_d, busy
   );
endinterface

// File: rtl/mcr_rom_arbiter.sv
// rtl/mcr_rom_arbiter.sv - single-port ROM shared by HPS download, main Z80 and sound Z80
// Optional per-requester one-entry read cache: define MCR_ROM_ARB_CACHE_EN.
module mcr_rom_arbiter #(
   parameter int          AW       = 16,
   parameter int          DW       = 8,
   parameter int          RD_LAT   = 1,
   parameter logic [15:0] SND_BASE = 16'hC000
) (
   input logic                clk_sys,
   input logic                reset_n,
   mcr_rom_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, READ, DL} state_t;

   state_t        state, state_nxt;
   logic          rr_last;          // 1 = sound CPU was granted last
   logic          gnt_snd;
   logic [1:0]    lat_cnt;
   logic          gnt_snd_c;
   logic          any_req;
   logic          hit;
   logic          cap_cpu, cap_snd;
   logic [AW-1:0] snd_rom_addr;

   assign any_req      = bus.cpu_req | bus.snd_req;
   assign gnt_snd_c    = bus.snd_req & (~bus.cpu_req | ~rr_last);
   assign snd_rom_addr = AW'(SND_BASE) + AW'(bus.snd_addr);
   assign cap_cpu      = (state == READ) & ~bus.dl_active & (lat_cnt == 2'd1) & ~gnt_snd & bus.cpu_req;
   assign cap_snd      = (state == READ) & ~bus.dl_active & (lat_cnt == 2'd1) & gnt_snd & bus.snd_req;

`ifdef MCR_ROM_ARB_CACHE_EN
   logic          cpu_vld, snd_vld;
   logic [AW-1:0] cpu_tag;
   logic [13:0]   snd_tag;

   // Cached data is simply the last acked data register, so only tags are kept.
   assign hit = gnt_snd_c ? (snd_vld & (snd_tag == bus.snd_addr))
                          : (cpu_vld & (cpu_tag == bus.cpu_addr));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cpu_vld <= 1'b0;
         snd_vld <= 1'b0;
         cpu_tag <= '0;
         snd_tag <= '0;
      end else if (state != DL && state_nxt == DL) begin
         cpu_vld <= 1'b0;
         snd_vld <= 1'b0;
      end else begin
         if (cap_cpu) begin
            cpu_vld <= 1'b1;
            cpu_tag <= bus.cpu_addr;
         end
         if (cap_snd) begin
            snd_vld <= 1'b1;
            snd_tag <= bus.snd_addr;
         end
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.dl_active)          state_nxt = DL;
               else if (any_req && !hit)   state_nxt = READ;
         READ: if (bus.dl_active)          state_nxt = DL;
               else if (lat_cnt == 2'd1)   state_nxt = IDLE;
         DL:   if (!bus.dl_active)         state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bus.rom_addr <= '0;
         bus.rom_we   <= 1'b0;
         bus.rom_d    <= '0;
         bus.cpu_data <= '0;
         bus.cpu_ack  <= 1'b0;
         bus.snd_data <= '0;
         bus.snd_ack  <= 1'b0;
         rr_last      <= 1'b1;
         gnt_snd      <= 1'b0;
         lat_cnt      <= 2'd0;
      end else begin
         bus.cpu_ack <= 1'b0;
         bus.snd_ack <= 1'b0;
         bus.rom_we  <= 1'b0;
         if (bus.dl_active && bus.dl_wr) begin
            bus.rom_we   <= 1'b1;
            bus.rom_addr <= bus.dl_addr;
            bus.rom_d    <= bus.dl_data;
         end
         if (state == IDLE && !bus.dl_active && any_req) begin
            if (hit) begin
               bus.cpu_ack <= ~gnt_snd_c;
               bus.snd_ack <= gnt_snd_c;
            end else begin
               gnt_snd      <= gnt_snd_c;
               rr_last      <= gnt_snd_c;
               lat_cnt      <= 2'(RD_LAT);
               bus.rom_addr <= gnt_snd_c ? snd_rom_addr : bus.cpu_addr;
            end
         end
         if (state == READ && !bus.dl_active)
            lat_cnt <= lat_cnt - 2'd1;
         // A request withdrawn mid-access still runs to completion but leaves data untouched.
         if (cap_cpu) begin
            bus.cpu_data <= bus.rom_q;
            bus.cpu_ack  <= 1'b1;
         end
         if (cap_snd) begin
            bus.snd_data <= bus.rom_q;
            bus.snd_ack  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mcr_rom_arbiter.sv
// tb/tb_mcr_rom_arbiter.sv - directed self-checking bench for mcr_rom_arbiter
module tb_mcr_rom_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;

   mcr_rom_arbiter_if #(.AW(16), .DW(8)) bus ();

   mcr_rom_arbiter #(.AW(16), .DW(8), .RD_LAT(1), .SND_BASE(16'hC000)) dut (
      .clk_sys (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // ROM model: byte at a is a[7:0]^a[15:8]^5A, except 0x1234 = A5
   logic [7:0] mem [0:65535];
   bit         mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 65536; i++) begin
            logic [15:0] a;
            a = i[15:0];
            mem[i] <= a[7:0] ^ a[15:8] ^ 8'h5A;
         end
         mem[16'h1234] <= 8'hA5;
         mem_init      <= 1'b1;
      end else if (bus.rom_we) begin
         mem[bus.rom_addr] <= bus.rom_d;
      end
   end
   assign bus.rom_q = mem[bus.rom_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.dl_active = 1'b0;
      bus.dl_wr     = 1'b0;
      bus.dl_addr   = '0;
      bus.dl_data   = '0;
      bus.cpu_req   = 1'b0;
      bus.cpu_addr  = '0;
      bus.snd_req   = 1'b0;
      bus.snd_addr  = '0;
      step(); step(); step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_rom_we", bus.rom_we, 0);
      chk("rst_acks", {bus.cpu_ack, bus.snd_ack}, 0);
      chk("rst_data", {bus.cpu_data, bus.snd_data}, 0);
      rst_n = 1'b1;
      step();

      // single CPU read
      bus.cpu_addr = 16'h1234;
      bus.cpu_req  = 1'b1;
      step();
      chk("t1_grant_busy", bus.busy, 1);
      chk("t1_rom_addr", bus.rom_addr, 16'h1234);
      chk("t1_no_ack_yet", bus.cpu_ack, 0);
      step();
      chk("t1_ack", bus.cpu_ack, 1);
      chk("t1_data", bus.cpu_data, 8'hA5);
      chk("t1_no_snd_ack", bus.snd_ack, 0);
      bus.cpu_req = 1'b0;
      step();
      chk("t1_ack_pulse", bus.cpu_ack, 0);
      chk("t1_idle", bus.busy, 0);

`ifndef MCR_ROM_ARB_CACHE_EN
      // round robin from a fresh reset: CPU, SND, CPU
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.cpu_addr = 16'h0020;
      bus.snd_addr = 14'h0010;
      bus.cpu_req  = 1'b1;
      bus.snd_req  = 1'b1;
      step();
      chk("t2_g1_addr", bus.rom_addr, 16'h0020);
      step();
      chk("t2_a1", {bus.cpu_ack, bus.snd_ack}, 2'b10);
      chk("t2_a1_data", bus.cpu_data, 8'h7A);
      step();
      chk("t2_g2_addr", bus.rom_addr, 16'hC010);
      chk("t2_g2_noack", {bus.cpu_ack, bus.snd_ack}, 2'b00);
      step();
      chk("t2_a2", {bus.cpu_ack, bus.snd_ack}, 2'b01);
      chk("t2_a2_data", bus.snd_data, 8'h8A);
      step();
      chk("t2_g3_addr", bus.rom_addr, 16'h0020);
      step();
      chk("t2_a3", {bus.cpu_ack, bus.snd_ack}, 2'b10);
      bus.cpu_req = 1'b0;
      bus.snd_req = 1'b0;
      step();
`endif

      // download with a CPU request held throughout
      bus.cpu_addr  = 16'h0002;
      bus.cpu_req   = 1'b1;
      bus.dl_active = 1'b1;
      step();
      chk("t3_dl_busy", bus.busy, 1);
      for (int i = 0; i < 4; i++) begin
         bus.dl_wr   = 1'b1;
         bus.dl_addr = 16'(i);
         bus.dl_data = 8'(8'h11 * (i + 1));
         step();
         chk("t3_we", bus.rom_we, 1);
         chk("t3_addr", bus.rom_addr, i);
         chk("t3_d", bus.rom_d, 8'h11 * (i + 1));
         bus.dl_wr = 1'b0;
         step();
         chk("t3_we_low", bus.rom_we, 0);
         chk("t3_no_ack", bus.cpu_ack, 0);
      end
      bus.dl_active = 1'b0;
      step();
      chk("t3_exit_idle", bus.busy, 0);
      chk("t3_exit_noack", bus.cpu_ack, 0);
      step();
      chk("t3_grant", bus.rom_addr, 16'h0002);
      step();
      chk("t3_ack", bus.cpu_ack, 1);
      chk("t3_data", bus.cpu_data, 8'h33);
      bus.cpu_req = 1'b0;
      step();

      // download aborts an in-flight read; the request is re-served with fresh data
      bus.cpu_addr = 16'h0040;
      bus.cpu_req  = 1'b1;
      step();
      chk("t4_read", bus.busy, 1);
      bus.dl_active = 1'b1;
      bus.dl_wr     = 1'b1;
      bus.dl_addr   = 16'h0040;
      bus.dl_data   = 8'hEE;
      step();
      chk("t4_abort_noack", bus.cpu_ack, 0);
      chk("t4_abort_busy", bus.busy, 1);
      chk("t4_abort_we", bus.rom_we, 1);
      bus.dl_wr = 1'b0;
      step();
      chk("t4_dl_noack", bus.cpu_ack, 0);
      bus.dl_active = 1'b0;
      step();
      chk("t4_exit_noack", bus.cpu_ack, 0);
      step();
      chk("t4_regrant", bus.rom_addr, 16'h0040);
      step();
      chk("t4_ack", bus.cpu_ack, 1);
      chk("t4_data", bus.cpu_data, 8'hEE);
      bus.cpu_req = 1'b0;
      step();

      // request withdrawn mid-access: no ack, data unchanged
      bus.cpu_addr = 16'h0050;
      bus.cpu_req  = 1'b1;
      step();
      bus.cpu_req = 1'b0;
      step();
      chk("drop_noack", bus.cpu_ack, 0);
      chk("drop_data", bus.cpu_data, 8'hEE);
      step();
      chk("drop_noack2", bus.cpu_ack, 0);

`ifdef MCR_ROM_ARB_CACHE_EN
      bus.cpu_addr = 16'h0100;
      bus.cpu_req  = 1'b1;
      step();
      chk("c_miss_busy", bus.busy, 1);
      step();
      chk("c_miss_ack", bus.cpu_ack, 1);
      chk("c_miss_data", bus.cpu_data, 8'h5B);
      bus.cpu_req = 1'b0;
      step();
      bus.cpu_req = 1'b1;
      step();
      chk("c_hit_ack", bus.cpu_ack, 1);
      chk("c_hit_busy", bus.busy, 0);
      chk("c_hit_data", bus.cpu_data, 8'h5B);
      bus.cpu_req  = 1'b0;
      bus.cpu_addr = 16'h0000;
      step();
      bus.dl_active = 1'b1;
      step();
      bus.dl_active = 1'b0;
      step();
      bus.cpu_addr = 16'h0100;
      bus.cpu_req  = 1'b1;
      step();
      chk("c_post_dl_noack", bus.cpu_ack, 0);
      chk("c_post_dl_busy", bus.busy, 1);
      step();
      chk("c_post_dl_ack", bus.cpu_ack, 1);
      bus.cpu_req = 1'b0;
      step();
`endif

      // asynchronous reset in the middle of a read
      bus.cpu_addr = 16'h1234;
      bus.cpu_req  = 1'b1;
      step();
      chk("t5_pre_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_addr", bus.rom_addr, 0);
      chk("t5_async_busy", bus.busy, 0);
      chk("t5_async_data", bus.cpu_data, 0);
      bus.cpu_req = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("t5_noack1", {bus.cpu_ack, bus.snd_ack}, 0);
      step();
      chk("t5_noack2", {bus.cpu_ack, bus.snd_ack}, 0);

      // sound CPU at offset 0 maps to SND_BASE
      bus.snd_addr = 14'h0000;
      bus.snd_req  = 1'b1;
      step();
      chk("snd_addr_map", bus.rom_addr, 16'hC000);
      step();
      chk("snd_ack", {bus.cpu_ack, bus.snd_ack}, 2'b01);
      chk("snd_data", bus.snd_data, 8'h9A);
      bus.snd_req = 1'b0;
      step();
      chk("snd_ack_pulse", bus.snd_ack, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
